// File: rtl/sub_16_serial.sv
// Bit-serial 16-bit subtractor: one full-subtractor cell resolves one bit per clock, LSB first.
// Results and flags are registered and change only when an operation completes.
module sub_16_serial (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [15:0] IN0,
  input  logic [15:0] IN1,
  input  logic        BIN,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] DIFF,
  output logic        BOUT,
  output logic        ZERO,
  output logic        NEG,
  output logic        OVF
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [14:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        br_q, br_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [15:0] diff_q, diff_d;
  logic        bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic        bit_a, bit_b, bit_d, br_nx;
  logic [15:0] full_res;

  always_comb begin
    bit_a    = a_q[0];
    bit_b    = b_q[0];
    bit_d    = bit_a ^ bit_b ^ br_q;
    br_nx    = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);
    // On the last bit the result register holds bits 0..14; bit 15 is still on the cell output.
    full_res = {bit_d, res_q};

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          a_d     = IN0;
          b_d     = IN1;
          br_d    = BIN;
          res_d   = 15'd0;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d   = {1'b0, a_q[15:1]};
        b_d   = {1'b0, b_q[15:1]};
        br_d  = br_nx;
        res_d = {bit_d, res_q[14:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = full_res;
          bout_d  = br_nx;
          zero_d  = (full_res == 16'd0);
          neg_d   = bit_d;
          // Operand sign bits are the last bits to reach the cell.
          ovf_d   = (bit_a != bit_b) && (bit_d != bit_a);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      res_q   <= 15'd0;
      cnt_q   <= 4'd0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= 16'd0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign ZERO = zero_q;
  assign NEG  = neg_q;
  assign OVF  = ovf_q;

endmodule

// File: tb/tb_sub_16_serial.sv
// Directed bench for sub_16_serial: hand-computed vectors, handshake timing, back-to-back and reset abort.
module tb_sub_16_serial;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [15:0] IN0 = 16'd0, IN1 = 16'd0;
  logic        BIN = 1'b0;
  logic        BUSY, DONE, BOUT, ZERO, NEG, OVF;
  logic [15:0] DIFF;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] prev_diff = 16'd0;

  sub_16_serial dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IN0(IN0), .IN1(IN1), .BIN(BIN),
    .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BOUT(BOUT), .ZERO(ZERO), .NEG(NEG), .OVF(OVF)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] ed,
                              input logic eb, input logic ez, input logic en, input logic eo);
    check({tag, ".diff"}, {16'd0, DIFF}, {16'd0, ed});
    check({tag, ".flags"}, {28'd0, BOUT, ZERO, NEG, OVF}, {28'd0, eb, ez, en, eo});
  endtask

  // Called at a negedge; returns at the negedge after DONE drops.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                        input logic [15:0] ed, input logic eb, input logic ez,
                        input logic en, input logic eo, input bit glitch);
    START = 1'b1; IN0 = a; IN1 = b; BIN = bi;
    @(negedge CLK);
    START = 1'b0; IN0 = 16'hDEAD; IN1 = 16'hBEEF; BIN = 1'b1;
    check({tag, ".busy_start"}, {30'd0, BUSY, DONE}, {30'd0, 2'b10});
    for (int i = 0; i < 15; i++) begin
      START = (glitch && i == 4) ? 1'b1 : 1'b0;
      if (glitch && i == 4) begin IN0 = 16'h0001; IN1 = 16'h0002; BIN = 1'b0; end
      @(negedge CLK);
    end
    START = 1'b0;
    check({tag, ".busy_last"}, {30'd0, BUSY, DONE}, {30'd0, 2'b10});
    check({tag, ".no_partial"}, {16'd0, DIFF}, {16'd0, prev_diff});
    @(negedge CLK);
    check({tag, ".done"}, {30'd0, BUSY, DONE}, {30'd0, 2'b01});
    check_result(tag, ed, eb, ez, en, eo);
    $display("op %s: %h - %h - %b -> diff=%h bout=%b zero=%b neg=%b ovf=%b",
             tag, a, b, bi, DIFF, BOUT, ZERO, NEG, OVF);
    prev_diff = ed;
    @(negedge CLK);
    check({tag, ".done_drop"}, {30'd0, BUSY, DONE}, {30'd0, 2'b00});
    check({tag, ".hold"}, {16'd0, DIFF}, {16'd0, ed});
  endtask

  task automatic wait_done(input string tag, output int t);
    bit seen = 1'b0;
    t = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (DONE) begin seen = 1'b1; t = cyc; end
    end
    check({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int t, last;
    logic [15:0] ba[3] = '{16'd20, 16'd10, 16'd100};
    logic [15:0] bb[3] = '{16'd10, 16'd20, 16'd100};
    logic [15:0] bd[3] = '{16'h000A, 16'hFFF6, 16'h0000};
    logic [3:0]  bf[3] = '{4'b0000, 4'b1010, 4'b0100};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset.ctl", {30'd0, BUSY, DONE}, 32'd0);
    check_result("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;

    run_op("sub_20_10",   16'd20,    16'd10,    1'b0, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_10_20",   16'd10,    16'd20,    1'b0, 16'hFFF6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_8000",    16'h8000,  16'h0001,  1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("borrow_in",   16'd20000, 16'd101,   1'b1, 16'h4DBA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("zero",        16'd100,   16'd100,   1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("zero_bin",    16'h0000,  16'h0000,  1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_neg",     16'h7FFF,  16'hFFFF,  1'b0, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("start_in_sh", 16'h1234,  16'h0234,  1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back with START held: one DONE every 17 cycles
    START = 1'b1; IN0 = ba[0]; IN1 = bb[0]; BIN = 1'b0;
    @(negedge CLK);
    IN0 = ba[1]; IN1 = bb[1];
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_done($sformatf("b2b%0d", k), t);
      check_result($sformatf("b2b%0d", k), bd[k], bf[k][3], bf[k][2], bf[k][1], bf[k][0]);
      $display("op b2b%0d: %h - %h -> diff=%h at cycle %0d", k, ba[k], bb[k], DIFF, t);
      if (k > 0) check($sformatf("b2b%0d.period", k), t - last, 32'd17);
      last = t;
      if (k < 2) begin
        @(negedge CLK);
        check($sformatf("b2b%0d.rebusy", k), {30'd0, BUSY, DONE}, {30'd0, 2'b10});
        if (k == 0) begin IN0 = ba[2]; IN1 = bb[2]; end
        else START = 1'b0;
      end
    end
    START = 1'b0;
    prev_diff = 16'h0000;
    repeat (2) @(negedge CLK);

    // Leave a nonzero result, then abort an operation with reset at the 5th shift cycle
    run_op("pre_abort", 16'd50, 16'd7, 1'b0, 16'h002B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    START = 1'b1; IN0 = 16'd9; IN1 = 16'd3; BIN = 1'b0;
    @(negedge CLK);
    START = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    check("abort.ctl", {30'd0, BUSY, DONE}, 32'd0);
    check_result("abort", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    check("abort.no_done", {30'd0, BUSY, DONE}, 32'd0);
    RST_N = 1'b1;
    prev_diff = 16'h0000;
    run_op("after_abort", 16'd20000, 16'd101, 1'b1, 16'h4DBA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
